// File: rtl/uart_echo_responder_if.sv
// ---------------------------------------------------------------------------
// uart_echo_responder_if
// Bus bundle between the echo responder and one uart_protocol instance.
//
//   rx_status    : RX_status_register ([7] read_not_ready, [6] overflow,
//                  [5] stop_err, [4] break_err, [3] parity_err, [2] empty,
//                  [1] full, [0] error_write)
//   tx_status    : TX_status_register ([2] empty, [1] full, [0] error_write)
//   bus_data_out : byte read from the RX FIFO
//   read_data    : one-cycle RX FIFO read strobe
//   write_data   : one-cycle TX FIFO write strobe
//   bus_data_in  : byte to the TX FIFO, valid while write_data = 1
//
// master = responder side, slave = uart_protocol side.
// ---------------------------------------------------------------------------
interface uart_echo_responder_if #(
    parameter int DATA_SIZE = 8
);
    logic [7:0]           rx_status;
    logic [7:0]           tx_status;
    logic [DATA_SIZE-1:0] bus_data_out;
    logic                 read_data;
    logic                 write_data;
    logic [DATA_SIZE-1:0] bus_data_in;

    modport master (
        input  rx_status, tx_status, bus_data_out,
        output read_data, write_data, bus_data_in
    );

    modport slave (
        output rx_status, tx_status, bus_data_out,
        input  read_data, write_data, bus_data_in
    );
endinterface

// File: rtl/uart_echo_responder.sv
// ---------------------------------------------------------------------------
// uart_echo_responder
// Drains bytes from a uart_protocol RX FIFO and writes them back into its TX
// FIFO, one byte in flight at a time, strictly in order. Keeps echo/drop
// statistics and a sticky TX-timeout flag for link bring-up and soak tests.
//
// Ports:
//   clk        : system clock
//   reset      : asynchronous, active-high reset
//   enable     : responder active (sampled in IDLE only)
//   bus        : uart_echo_responder_if.master (status, data and strobes)
//   busy       : FSM is not IDLE
//   echo_count : bytes echoed, wraps 16'hFFFF -> 0
//   drop_count : bytes dropped (RX error or TX timeout), saturates at 8'hFF
//   tx_timeout : sticky, set on any TX timeout, cleared only by reset
//
// Optional feature macro: UART_ECHO_XFORM_EN
//   defined   : echoed byte = data ^ XOR_MASK (default toggles ASCII case)
//   undefined : byte echoed unchanged
// ---------------------------------------------------------------------------
module uart_echo_responder #(
    parameter int                   DATA_SIZE  = 8,
    parameter int                   RD_LAT     = 1,
    parameter int                   TX_TIMEOUT = 65535,
    parameter logic [DATA_SIZE-1:0] XOR_MASK   = DATA_SIZE'(8'h20)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    uart_echo_responder_if.master  bus,
    output logic                   busy,
    output logic [15:0]            echo_count,
    output logic [7:0]             drop_count,
    output logic                   tx_timeout
);

`ifdef UART_ECHO_XFORM_EN
    localparam logic [DATA_SIZE-1:0] ECHO_MASK = XOR_MASK;
`else
    // Mask folds to zero: the XOR below is a constant pass-through.
    localparam logic [DATA_SIZE-1:0] ECHO_MASK = '0 & XOR_MASK;
`endif

    // One timer serves both WAIT (read latency) and TXW (full backoff).
    localparam int TMR_W     = ($clog2(TX_TIMEOUT + 1) > 2) ? $clog2(TX_TIMEOUT + 1) : 2;
    localparam int WAIT_LAST = (RD_LAT > 1) ? RD_LAT - 2 : 0;

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WAIT, S_CAP, S_TXW, S_WR, S_GAP
    } state_t;

    state_t               state_q, state_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [DATA_SIZE-1:0] data_q, data_d;
    logic                 read_data_q, read_data_d;
    logic                 write_data_q, write_data_d;
    logic [DATA_SIZE-1:0] bus_data_in_q, bus_data_in_d;
    logic                 busy_q, busy_d;
    logic [15:0]          echo_count_q, echo_count_d;
    logic [7:0]           drop_count_q, drop_count_d;
    logic                 tx_timeout_q, tx_timeout_d;

    logic rx_ready, rx_err, tx_full, wait_done, timer_done;
    logic unused_status;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign rx_ready   = !bus.rx_status[2] && !bus.rx_status[7];
    assign rx_err     = |bus.rx_status[6:3];
    assign tx_full    = bus.tx_status[1];
    assign wait_done  = (timer_q == TMR_W'(WAIT_LAST));
    // TXW is entered with timer 0, so this is its TX_TIMEOUT-th cycle.
    assign timer_done = (timer_q == TMR_W'(TX_TIMEOUT - 1));

    assign unused_status = ^{bus.rx_status[1:0], bus.tx_status[7:2], bus.tx_status[0]};

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            data_q        <= '0;
            read_data_q   <= 1'b0;
            write_data_q  <= 1'b0;
            bus_data_in_q <= '0;
            busy_q        <= 1'b0;
            echo_count_q  <= '0;
            drop_count_q  <= '0;
            tx_timeout_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            data_q        <= data_d;
            read_data_q   <= read_data_d;
            write_data_q  <= write_data_d;
            bus_data_in_q <= bus_data_in_d;
            busy_q        <= busy_d;
            echo_count_q  <= echo_count_d;
            drop_count_q  <= drop_count_d;
            tx_timeout_q  <= tx_timeout_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (enable && rx_ready) state_d = S_RD;
            S_RD:   state_d = (RD_LAT > 1) ? S_WAIT : S_CAP;
            S_WAIT: if (wait_done) state_d = S_CAP;
            S_CAP:  state_d = rx_err ? S_GAP : S_TXW;
            S_TXW: begin
                if (!tx_full)       state_d = S_WR;
                else if (timer_done) state_d = S_GAP;
            end
            S_WR:   state_d = S_GAP;
            S_GAP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath logic; strobes are decoded from the next state so the
    // registered versions line up with the RD and WR states.
    always_comb begin
        read_data_d   = (state_d == S_RD);
        write_data_d  = (state_d == S_WR);
        busy_d        = (state_d != S_IDLE);
        timer_d       = '0;
        data_d        = data_q;
        bus_data_in_d = bus_data_in_q;
        echo_count_d  = echo_count_q;
        drop_count_d  = drop_count_q;
        tx_timeout_d  = tx_timeout_q;

        if ((state_q == S_WAIT || state_q == S_TXW) && state_d == state_q)
            timer_d = timer_q + TMR_W'(1);

        if (state_q == S_CAP) begin
            data_d = bus.bus_data_out;
            if (rx_err) drop_count_d = sat_inc8(drop_count_q);
        end

        if (state_q == S_TXW && tx_full && timer_done) begin
            drop_count_d = sat_inc8(drop_count_q);
            tx_timeout_d = 1'b1;
        end

        if (state_d == S_WR)
            bus_data_in_d = data_q ^ ECHO_MASK;

        if (state_q == S_WR)
            echo_count_d = echo_count_q + 16'd1;
    end

    assign bus.read_data   = read_data_q;
    assign bus.write_data  = write_data_q;
    assign bus.bus_data_in = bus_data_in_q;
    assign busy            = busy_q;
    assign echo_count      = echo_count_q;
    assign drop_count      = drop_count_q;
    assign tx_timeout      = tx_timeout_q;

endmodule
